// File: rtl/wb_commit_pkg.sv
// Shared types for the writeback commit stage: register address/word types,
// the writeback source enum and the registered write-port bundle.
package wb_commit_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef logic [4:0]      creg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    // Identifies which producer owns the write port in a given cycle.
    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM,
        WB_MDU
    } wb_src_e;

    typedef struct packed {
        logic       wvalid;
        creg_addr_t wa;
        word_t      wd;
    } wb_write_t;

    // One-hot register mask; x0 never produces a bit.
    function automatic logic [NREGS-1:0] reg_onehot(input logic en, input creg_addr_t rd);
        logic [NREGS-1:0] mask;
        mask = '0;
        if (en && (rd != '0)) begin
            mask[rd] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_prio_arb.sv
// Writeback arbiter: picks one of ALU/MEM/MDU per cycle, with aging counters
// that promote a long-waiting MEM or MDU result above the ALU.
module wb_prio_arb
    import wb_commit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    alu_valid,
    input  logic    mem_valid,
    input  logic    mdu_valid,
    output wb_src_e src
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);

    // Index 0 tracks MEM, index 1 tracks MDU.
    logic [1:0]             aged_valid;
    logic [1:0]             aged_grant;
    logic [1:0][WAIT_W-1:0] waits;

    assign aged_valid = {mdu_valid, mem_valid};
    assign aged_grant = {src == WB_MDU, src == WB_MEM};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wait
            logic [WAIT_W-1:0] wait_reg;
            logic [WAIT_W-1:0] wait_next;

            always_comb begin
                wait_next = '0;
                if (aged_valid[gi] && !aged_grant[gi]) begin
                    wait_next = (wait_reg == LIMIT) ? LIMIT : wait_reg + WAIT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wait_reg <= '0;
                end else begin
                    wait_reg <= wait_next;
                end
            end

            assign waits[gi] = wait_reg;
        end
    endgenerate

    // Starved MDU beats starved MEM; MEM stays starved and wins next.
    always_comb begin
        src = WB_NONE;
        if (mdu_valid && (waits[1] == LIMIT)) begin
            src = WB_MDU;
        end else if (mem_valid && (waits[0] == LIMIT)) begin
            src = WB_MEM;
        end else if (alu_valid) begin
            src = WB_ALU;
        end else if (mem_valid) begin
            src = WB_MEM;
        end else if (mdu_valid) begin
            src = WB_MDU;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback commit stage: arbitrates producer results onto the register file
// write port, tracks registers owed long-latency results and counts commits.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  creg_addr_t       alu_rd,
    input  word_t            alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  creg_addr_t       mem_rd,
    input  word_t            mem_data,
    input  logic             mdu_valid,
    output logic             mdu_ready,
    input  creg_addr_t       mdu_rd,
    input  word_t            mdu_data,
    input  logic             issue_valid,
    input  creg_addr_t       issue_rd,
    output logic             wvalid,
    output creg_addr_t       wa,
    output word_t            wd,
    output logic [NREGS-1:0] pending,
    output logic [CNT_W-1:0] commit_cnt
);

    wb_src_e src;

    wb_prio_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .alu_valid(alu_valid),
        .mem_valid(mem_valid),
        .mdu_valid(mdu_valid),
        .src      (src)
    );

    assign alu_ready = (src == WB_ALU) && !reset;
    assign mem_ready = (src == WB_MEM) && !reset;
    assign mdu_ready = (src == WB_MDU) && !reset;

    logic xfer_alu, xfer_mem, xfer_mdu, any_xfer;

    assign xfer_alu = alu_valid && alu_ready;
    assign xfer_mem = mem_valid && mem_ready;
    assign xfer_mdu = mdu_valid && mdu_ready;
    assign any_xfer = xfer_alu || xfer_mem || xfer_mdu;

    creg_addr_t sel_rd;
    word_t      sel_data;
    wb_write_t  wb_reg, wb_next;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (src)
            WB_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            WB_MEM: begin
                sel_rd   = mem_rd;
                sel_data = mem_data;
            end
            WB_MDU: begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
            end
            default: ;
        endcase

        // wa/wd hold between transfers; only the strobe drops.
        wb_next        = wb_reg;
        wb_next.wvalid = 1'b0;
        if (any_xfer) begin
            wb_next.wvalid = (sel_rd != '0);
            wb_next.wa     = sel_rd;
            wb_next.wd     = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_reg <= '0;
        end else begin
            wb_reg <= wb_next;
        end
    end

    assign wvalid = wb_reg.wvalid;
    assign wa     = wb_reg.wa;
    assign wd     = wb_reg.wd;

    logic [NREGS-1:0] set_mask, clr_mask;
    logic [NREGS-1:0] pending_reg, pending_next;

    assign set_mask = reg_onehot(issue_valid, issue_rd);
    assign clr_mask = reg_onehot(xfer_mem, mem_rd) | reg_onehot(xfer_mdu, mdu_rd);

    // A same-cycle issue to the register being retired re-owns it.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign pending_next[gi] = set_mask[gi] | (pending_reg[gi] & ~clr_mask[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending = pending_reg;

    logic [CNT_W-1:0] commit_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt_reg <= '0;
        end else if (any_xfer) begin
            commit_cnt_reg <= commit_cnt_reg + CNT_W'(1);
        end
    end

    assign commit_cnt = commit_cnt_reg;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: expected writes are queued when a transfer is
// expected and popped for comparison after the output register loads.
module tb_wb_commit;
    import wb_commit_pkg::*;

    logic        clk;
    logic        reset;
    logic        alu_valid, mem_valid, mdu_valid;
    logic        alu_ready, mem_ready, mdu_ready;
    creg_addr_t  alu_rd, mem_rd, mdu_rd, issue_rd;
    word_t       alu_data, mem_data, mdu_data;
    logic        issue_valid;
    logic        wvalid;
    creg_addr_t  wa;
    word_t       wd;
    logic [31:0] pending;
    logic [63:0] commit_cnt;

    wb_commit #(.STARVE_LIMIT(4), .CNT_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .wvalid     (wvalid),
        .wa         (wa),
        .wd         (wd),
        .pending    (pending),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [63:0] wd;
    } wr_t;

    wr_t         exp_q[$];
    int          tests  = 0;
    int          failed = 0;
    logic [4:0]  exp_wa;
    logic [63:0] exp_wd;
    logic [63:0] exp_cnt;
    logic [31:0] exp_pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_valid = 0; mem_valid = 0; mdu_valid = 0; issue_valid = 0;
        alu_rd = 0; mem_rd = 0; mdu_rd = 0; issue_rd = 0;
        alu_data = 0; mem_data = 0; mdu_data = 0;
    endtask

    // One cycle: check readies before the edge, queue the expected write,
    // then compare the registered outputs just after the edge.
    task automatic tick(input logic e_alu, input logic e_mem, input logic e_mdu);
        wr_t         w;
        wr_t         got;
        logic [31:0] nxt;
        @(negedge clk);
        check("alu_ready", 64'(alu_ready), 64'(e_alu));
        check("mem_ready", 64'(mem_ready), 64'(e_mem));
        check("mdu_ready", 64'(mdu_ready), 64'(e_mdu));
        if (reset) begin
            w = '{wv: 1'b0, wa: 5'd0, wd: 64'd0};
            exp_cnt = 0;
            exp_pending = 0;
        end else begin
            w = '{wv: 1'b0, wa: exp_wa, wd: exp_wd};
            if (e_alu) w = '{wv: (alu_rd != 0), wa: alu_rd, wd: alu_data};
            if (e_mem) w = '{wv: (mem_rd != 0), wa: mem_rd, wd: mem_data};
            if (e_mdu) w = '{wv: (mdu_rd != 0), wa: mdu_rd, wd: mdu_data};
            if (e_alu || e_mem || e_mdu) exp_cnt++;
            nxt = exp_pending;
            if (e_mem) nxt[mem_rd] = 1'b0;
            if (e_mdu) nxt[mdu_rd] = 1'b0;
            if (issue_valid) nxt[issue_rd] = 1'b1;
            nxt[0] = 1'b0;
            exp_pending = nxt;
        end
        exp_wa = w.wa;
        exp_wd = w.wd;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        $display("[TB] t=%0t wvalid=%0b wa=%0d wd=%h cnt=%0d pending=%h", $time, wvalid, wa, wd, commit_cnt, pending);
        check("wvalid", 64'(wvalid), 64'(got.wv));
        check("wa", 64'(wa), 64'(got.wa));
        check("wd", wd, got.wd);
        check("commit_cnt", commit_cnt, exp_cnt);
        check("pending", 64'(pending), 64'(exp_pending));
    endtask

    initial begin
        exp_wa = 0; exp_wd = 0; exp_cnt = 0; exp_pending = 0;
        clear_inputs();

        // Reset with every producer valid: no ready may rise.
        reset = 1;
        alu_valid = 1; alu_rd = 1; mem_valid = 1; mem_rd = 2; mdu_valid = 1; mdu_rd = 3;
        tick(0, 0, 0);
        tick(0, 0, 0);
        reset = 0;
        clear_inputs();
        tick(0, 0, 0);

        // ALU only, then hold of wa/wd with no transfer.
        alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        tick(1, 0, 0);
        clear_inputs();
        tick(0, 0, 0);

        // Write to x0 is counted but never signalled.
        alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
        tick(1, 0, 0);
        clear_inputs();

        // Fixed priority ALU > MEM > MDU.
        alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
        mem_valid = 1; mem_rd = 2; mem_data = 64'h22;
        mdu_valid = 1; mdu_rd = 3; mdu_data = 64'h33;
        tick(1, 0, 0);
        tick(1, 0, 0);
        alu_valid = 0;
        tick(0, 1, 0);
        mem_valid = 0;
        tick(0, 0, 1);
        clear_inputs();
        tick(0, 0, 0);

        // MDU starvation: promoted on the fifth cycle of waiting.
        alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
        mdu_valid = 1; mdu_rd = 10; mdu_data = 64'hAA;
        for (int i = 0; i < 4; i++) tick(1, 0, 0);
        check("mdu_wait_sat", 64'(dut.u_arb.g_wait[1].wait_reg), 64'd4);
        tick(0, 0, 1);
        mdu_valid = 0;
        check("mdu_wait_clr", 64'(dut.u_arb.g_wait[1].wait_reg), 64'd0);
        tick(1, 0, 0);
        clear_inputs();

        // Both starved: MDU first, then MEM ahead of the ALU.
        alu_valid = 1; alu_rd = 11; alu_data = 64'hB0;
        mem_valid = 1; mem_rd = 12; mem_data = 64'hC0;
        mdu_valid = 1; mdu_rd = 13; mdu_data = 64'hD0;
        for (int i = 0; i < 4; i++) tick(1, 0, 0);
        tick(0, 0, 1);
        mdu_valid = 0;
        tick(0, 1, 0);
        mem_valid = 0;
        tick(1, 0, 0);
        clear_inputs();

        // Scoreboard set, clear, and set-beats-clear.
        issue_valid = 1; issue_rd = 7;
        tick(0, 0, 0);
        clear_inputs();
        mem_valid = 1; mem_rd = 7; mem_data = 64'h77;
        tick(0, 1, 0);
        clear_inputs();
        issue_valid = 1; issue_rd = 7;
        tick(0, 0, 0);
        mdu_valid = 1; mdu_rd = 7; mdu_data = 64'h7777;
        tick(0, 0, 1);
        clear_inputs();
        issue_valid = 1; issue_rd = 0;
        tick(0, 0, 0);
        clear_inputs();

        // Build pending=0xF0 and mem_wait=3, then reset mid-operation.
        alu_valid = 1; alu_rd = 14; alu_data = 64'hE0;
        mem_valid = 1; mem_rd = 15; mem_data = 64'hF0;
        for (int i = 4; i < 7; i++) begin
            issue_valid = 1; issue_rd = 5'(i);
            tick(1, 0, 0);
        end
        issue_valid = 0;
        check("pending_F0", 64'(pending), 64'h00F0);
        check("mem_wait_3", 64'(dut.u_arb.g_wait[0].wait_reg), 64'd3);
        reset = 1;
        tick(0, 0, 0);
        reset = 0;
        check("mem_wait_rst", 64'(dut.u_arb.g_wait[0].wait_reg), 64'd0);
        tick(1, 0, 0);
        alu_valid = 0;
        tick(0, 1, 0);
        clear_inputs();
        tick(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
